// File: rtl/knight_rider_sweep.sv
// knight_rider_sweep: single lit LED bouncing across the bank, with optional dwell at each end.
// Define KRF_TRAIL_EN to add a two-entry comet tail behind the lit LED.
module knight_rider_sweep #(
    parameter int NUM_LEDS  = 10,
    parameter int END_DWELL = 2,
    parameter int POS_W     = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic                step,
    output logic [NUM_LEDS-1:0] leds,
    output logic [POS_W-1:0]    position,
    output logic                direction,
    output logic                end_pulse
);
    typedef enum logic [1:0] {IDLE, RUN, DWELL} state_t;
    localparam logic [POS_W-1:0] LAST = POS_W'(NUM_LEDS - 1);
    localparam logic [3:0] DW = 4'(END_DWELL);
    state_t state, state_n;
    logic [POS_W-1:0] pos_n, away;
    logic [3:0] cnt, cnt_n;
    logic flag, flag_n, dir_n, pulse_n, at_end;
    logic [NUM_LEDS-1:0] leds_n, tail_n;
    assign at_end = direction ? position == '0 : position == LAST;
    assign away = direction ? position + POS_W'(1) : position - POS_W'(1);
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            position <= '0;
            direction <= 1'b0;
            cnt <= '0;
            flag <= 1'b0;
            end_pulse <= 1'b0;
            leds <= '0;
        end else begin
            state <= state_n;
            position <= pos_n;
            direction <= dir_n;
            cnt <= cnt_n;
            flag <= flag_n;
            end_pulse <= pulse_n;
            leds <= leds_n;
        end
    end
    // flag remembers an interrupted dwell so re-enable resumes DWELL
    always_comb begin
        state_n = state;
        pos_n = position;
        dir_n = direction;
        cnt_n = cnt;
        flag_n = flag;
        pulse_n = 1'b0;
        if (!enable) begin
            state_n = IDLE;
        end else if (state == IDLE) begin
            state_n = flag ? DWELL : RUN;
        end else if (step) begin
            if (state == RUN) begin
                if (!at_end) begin
                    pos_n = direction ? position - POS_W'(1) : position + POS_W'(1);
                end else if (END_DWELL == 0) begin
                    dir_n = ~direction;
                    pos_n = away;
                    pulse_n = 1'b1;
                end else begin
                    state_n = DWELL;
                    cnt_n = 4'd1;
                    flag_n = 1'b1;
                end
            end else if (cnt < DW) begin
                cnt_n = cnt + 4'd1;
            end else begin
                dir_n = ~direction;
                pos_n = away;
                cnt_n = '0;
                flag_n = 1'b0;
                pulse_n = 1'b1;
                state_n = RUN;
            end
        end
    end
    assign leds_n = (state_n == IDLE) ? '0 : (NUM_LEDS'(1) << pos_n) | tail_n;
`ifdef KRF_TRAIL_EN
    logic [POS_W-1:0] h1, h2;
    logic [1:0] hv, hv_n;
    logic shift;
    // every accepted step moves the head or, while dwelling, folds the tail onto the end LED
    assign shift = enable && state != IDLE && step;
    assign hv_n = (state_n == IDLE) ? 2'b00 : shift ? {hv[0], 1'b1} : hv;
    assign tail_n = (hv_n[0] ? NUM_LEDS'(1) << (shift ? position : h1) : '0)
                  | (hv_n[1] ? NUM_LEDS'(1) << (shift ? h1 : h2) : '0);
    always_ff @(posedge clock) begin
        if (reset) begin
            h1 <= '0;
            h2 <= '0;
            hv <= 2'b00;
        end else begin
            hv <= hv_n;
            if (shift) begin
                h1 <= position;
                h2 <= h1;
            end
        end
    end
`else
    assign tail_n = '0;
`endif
endmodule

// File: tb/tb_knight_rider_sweep.sv
// tb_knight_rider_sweep: directed vector table on an END_DWELL=0 sweep plus dwell/resume sequences on END_DWELL=2.
module tb_knight_rider_sweep;
    logic clock = 1'b0;
    logic a_rst = 1'b1, a_en = 1'b0, a_st = 1'b0;
    logic b_rst = 1'b1, b_en = 1'b0, b_st = 1'b0;
    logic [9:0] a_leds, b_leds;
    logic [3:0] a_pos, b_pos;
    logic a_dir, b_dir, a_pul, b_pul;
    int errors = 0;
    int checks = 0;

    typedef struct {
        logic rst, en, st;
        logic [9:0] leds;
        logic [3:0] pos;
        logic dir, pul;
    } vec_t;
    vec_t vq[$];

    always #5 clock = ~clock;

    knight_rider_sweep #(.NUM_LEDS(10), .END_DWELL(0), .POS_W(4)) dut_a (
        .clock(clock), .reset(a_rst), .enable(a_en), .step(a_st),
        .leds(a_leds), .position(a_pos), .direction(a_dir), .end_pulse(a_pul)
    );
    knight_rider_sweep #(.NUM_LEDS(10), .END_DWELL(2), .POS_W(4)) dut_b (
        .clock(clock), .reset(b_rst), .enable(b_en), .step(b_st),
        .leds(b_leds), .position(b_pos), .direction(b_dir), .end_pulse(b_pul)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick_a(input logic r, input logic e, input logic s);
        a_rst = r; a_en = e; a_st = s;
        @(posedge clock); #1;
    endtask

    task automatic tick_b(input logic r, input logic e, input logic s);
        b_rst = r; b_en = e; b_st = s;
        @(posedge clock); #1;
    endtask

    task automatic chk_b(input string name, input logic [9:0] l, input logic [3:0] p, input logic d, input logic u);
        chk({name, ".leds"}, 32'(b_leds), 32'(l));
        chk({name, ".pos"}, 32'(b_pos), 32'(p));
        chk({name, ".dir"}, 32'(b_dir), 32'(d));
        chk({name, ".pulse"}, 32'(b_pul), 32'(u));
    endtask

    function automatic vec_t v(input logic r, input logic e, input logic s, input logic [9:0] l,
                               input logic [3:0] p, input logic d, input logic u);
        vec_t x;
        x.rst = r; x.en = e; x.st = s; x.leds = l; x.pos = p; x.dir = d; x.pul = u;
        return x;
    endfunction

    initial begin
        vq.push_back(v(1, 0, 0, 10'h000, 0, 0, 0));
        vq.push_back(v(0, 1, 0, 10'h001, 0, 0, 0));
        for (int i = 1; i <= 9; i++) vq.push_back(v(0, 1, 1, 10'(1 << i), 4'(i), 0, 0));
        vq.push_back(v(0, 1, 1, 10'h100, 8, 1, 1));
        vq.push_back(v(0, 1, 0, 10'h100, 8, 1, 0));
        vq.push_back(v(0, 1, 1, 10'h080, 7, 1, 0));
        vq.push_back(v(0, 1, 1, 10'h040, 6, 1, 0));
        vq.push_back(v(0, 1, 1, 10'h020, 5, 1, 0));
        vq.push_back(v(1, 1, 1, 10'h000, 0, 0, 0));
        vq.push_back(v(0, 1, 1, 10'h001, 0, 0, 0));
        for (int i = 1; i <= 4; i++) vq.push_back(v(0, 1, 1, 10'(1 << i), 4'(i), 0, 0));
        for (int i = 0; i < 5; i++) vq.push_back(v(0, 0, 1, 10'h000, 4, 0, 0));
        vq.push_back(v(0, 1, 0, 10'h010, 4, 0, 0));
        for (int i = 5; i <= 9; i++) vq.push_back(v(0, 1, 1, 10'(1 << i), 4'(i), 0, 0));
        vq.push_back(v(0, 1, 1, 10'h100, 8, 1, 1));
        for (int i = 7; i >= 0; i--) vq.push_back(v(0, 1, 1, 10'(1 << i), 4'(i), 1, 0));
        vq.push_back(v(0, 1, 1, 10'h002, 1, 0, 1));
        vq.push_back(v(0, 1, 0, 10'h002, 1, 0, 0));

        foreach (vq[i]) begin
            tick_a(vq[i].rst, vq[i].en, vq[i].st);
`ifndef KRF_TRAIL_EN
            chk($sformatf("vec%0d.leds", i), 32'(a_leds), 32'(vq[i].leds));
`endif
            chk($sformatf("vec%0d.pos", i), 32'(a_pos), 32'(vq[i].pos));
            chk($sformatf("vec%0d.dir", i), 32'(a_dir), 32'(vq[i].dir));
            chk($sformatf("vec%0d.pulse", i), 32'(a_pul), 32'(vq[i].pul));
        end

        tick_a(1, 0, 0);
        tick_a(0, 1, 0);
        for (int i = 0; i < 3; i++) tick_a(0, 1, 1);
`ifdef KRF_TRAIL_EN
        chk("trail.leds", 32'(a_leds), 32'h00E);
`else
        chk("trail.leds", 32'(a_leds), 32'h008);
`endif
        chk("trail.pos", 32'(a_pos), 32'd3);
        tick_a(1, 1, 0);
        chk("trail.reset_leds", 32'(a_leds), 32'h000);

        tick_b(1, 0, 0);
        chk_b("b.reset", 10'h000, 0, 0, 0);
        tick_b(0, 1, 1);
        chk_b("b.enable_no_step", 10'h001, 0, 0, 0);
        for (int i = 0; i < 9; i++) tick_b(0, 1, 1);
        chk_b("b.top", 10'h200, 9, 0, 0);
        tick_b(0, 1, 1);
        chk_b("b.dwell1", 10'h200, 9, 0, 0);
        tick_b(0, 1, 1);
        chk_b("b.dwell2", 10'h200, 9, 0, 0);
        tick_b(0, 1, 1);
        chk_b("b.reverse", 10'h100, 8, 1, 1);
        tick_b(0, 1, 0);
        chk_b("b.pulse_done", 10'h100, 8, 1, 0);
        for (int i = 0; i < 8; i++) tick_b(0, 1, 1);
        chk_b("b.bottom", 10'h001, 0, 1, 0);
        tick_b(0, 1, 1);
        chk_b("b.bdwell1", 10'h001, 0, 1, 0);
        tick_b(0, 0, 1);
        chk_b("b.bdwell_off", 10'h000, 0, 1, 0);
        tick_b(0, 1, 0);
        chk_b("b.bdwell_resume", 10'h001, 0, 1, 0);
        tick_b(0, 1, 1);
        chk_b("b.bdwell2", 10'h001, 0, 1, 0);
        tick_b(0, 1, 1);
        chk_b("b.breverse", 10'h002, 1, 0, 1);
        tick_b(0, 1, 1);
        chk_b("b.after", 10'h004, 2, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/knight_rider_sweep.md
Name: knight_rider_sweep

Overview:
- Pattern-generation stage directly downstream of the on/off toggle latch and divide-by-N clock divider in the Knight Rider flasher.
- Consumes the gated enable and a one-cycle step tick; moves a single lit LED back and forth across the LED bank (LEDR[9:0] on DE1-SoC), with an optional dwell at each end.
- Exports position, direction and an end-reversal pulse for debug displays.

Parameters:
- NUM_LEDS, 10, number of LEDs in the bank; legal range 2..16.
- END_DWELL, 2, number of extra step ticks the lit LED is held at each end before reversing; 0 means reverse immediately; legal range 0..15.
- POS_W, 4, width of the position output; must satisfy 2**POS_W >= NUM_LEDS.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  run gate from the toggle latch; 1 = sweep runs, 0 = LEDs dark and state frozen.
- step  in  1  one-clock-wide advance tick from the divider; sampled only when enable = 1.
- leds  out  NUM_LEDS  LED drive; bit i lit means LED i is on.
- position  out  POS_W  current lit index, 0..NUM_LEDS-1.
- direction  out  1  0 = moving up (toward NUM_LEDS-1), 1 = moving down.
- end_pulse  out  1  one-cycle strobe when the direction reverses.

Behaviour:
- Clock and reset (already decided): one clock; reset is synchronous and active-high. Ports are named clock and reset.
- Reset state: position=0, direction=0, dwell count=0, state=IDLE, leds=0, end_pulse=0. Reset dominates all other inputs.
- State machine: IDLE, RUN, DWELL.
  - IDLE → RUN on the first clock with enable=1. This transition does not consume a step.
  - RUN or DWELL → IDLE on any clock with enable=0. Position, direction and dwell count are frozen. A later re-enable resumes RUN (or DWELL) from the frozen values; dwell is remembered via a stored flag.
- RUN, on step=1:
  - direction=0 and position<NUM_LEDS-1: position+1.
  - direction=1 and position>0: position-1.
  - At an end (position=NUM_LEDS-1 going up, or 0 going down):
    - END_DWELL=0: flip direction, move one position away from the end, pulse end_pulse.
    - END_DWELL>0: go to DWELL with dwell count=1; position is held.
- DWELL, on step=1:
  - dwell count<END_DWELL: increment dwell count.
  - dwell count=END_DWELL: flip direction, move one position away from the end, clear dwell count, pulse end_pulse, return to RUN.
- step=0: no state change.
- step while enable=0: ignored, never queued.
- Latency: leds, position, direction and end_pulse are all registered. They update on the clock edge that samples step=1, so they are visible one cycle after step is asserted.
- leds output:
  - IDLE: all zero.
  - RUN or DWELL: one-hot at position (without the optional feature).
- end_pulse is high for exactly one cycle per reversal and is 0 in all other cycles.
- Full sweep period with NUM_LEDS=10, END_DWELL=D: 2*(9+D) steps.
- Position never leaves 0..NUM_LEDS-1. There is no wrap-around from the top to the bottom; the sweep only bounces.

Optional Feature:
- Macro: KRF_TRAIL_EN.
- Defined:
  - leds also lights the two previously visited positions (comet tail). Tail entries are kept in a 2-deep history register, updated on every position change.
  - During DWELL, the tail collapses one entry per step onto the end LED.
  - History clears on reset and on entering IDLE.
  - The tail is never shown in IDLE.
- Undefined: leds is strictly one-hot; no history registers are synthesised.

Test Plan:
- Reset mid-sweep: reset=1 for one clock while position=5, direction=1 → next cycle position=0, direction=0, leds=0, end_pulse=0.
- Basic sweep: NUM_LEDS=10, END_DWELL=0, enable=1, 9 steps → leds 0x001, 0x002, … up to 0x200.
  - 10th step → position=8, direction=1, end_pulse high for exactly 1 cycle.
- Dwell: END_DWELL=2, position=9 going up → 3 further steps hold leds=0x200; the 3rd produces the reversal, giving position=8 and end_pulse=1.
- Enable gating: drop enable at position=4 while pulsing step 5 times → leds=0 and position stays 4.
  - Re-enable plus 1 step → position=5.
- Step/enable collision and back-to-back steps: step=1 in the same cycle enable falls → ignored.
  - step held high for 3 consecutive clocks in RUN → position advances by 3.
- KRF_TRAIL_EN defined: steps from position 0 to 3 → leds=0x00E.
  - After reset → 0x000.
